// File: rtl/sync_chain_x.sv
// Behavioural multi-stage synchroniser with injected metastability: violating
// captures randomise changing bits, and a flag tracks metastability down the chain.
// Optional statistics counters (VCNT/ECNT) are built only when SYNC_CHAIN_X_STATS_EN is defined.
module sync_chain_x #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             CK,
    input  logic             RS,
    input  logic [WIDTH-1:0] D,
    input  logic             V,
    input  logic [WIDTH-1:0] rD,
    input  logic             rV,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] T,
    output logic             M,
    output logic [CNT_W-1:0] VCNT,
    output logic [CNT_W-1:0] ECNT
);

    logic [STAGES-1:0][WIDTH-1:0] s_q;
    logic [STAGES-1:0]            m_q;
    logic [WIDTH-1:0]             t_q;

    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] s0_d;
    logic             m0_d;
    logic             viol_eff;
    logic             escape;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        chg      = D ^ s_q[0];
        viol_eff = V && (chg != '0);
        s0_d     = D;
        if (V) begin
            s0_d = (D & ~chg) | (rD & chg);
        end
        m0_d   = viol_eff && rV;
        escape = m_q[STAGES-2] && rV;
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            s_q <= '0;
            m_q <= '0;
            t_q <= '0;
        end else begin
            s_q[0] <= s0_d;
            m_q[0] <= m0_d;
            for (int k = 1; k < STAGES; k++) begin
                s_q[k] <= s_q[k-1];
                m_q[k] <= m_q[k-1] && rV;
            end
            t_q <= s_q[STAGES-2] ^ s_q[STAGES-1];
        end
    end

    assign Q = s_q[STAGES-1];
    assign T = t_q;
    assign M = m_q[STAGES-1];

`ifdef SYNC_CHAIN_X_STATS_EN
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;

    // Both counters hold at all-ones instead of wrapping.
    always_comb begin
        vcnt_d = vcnt_q;
        ecnt_d = ecnt_q;
        if (viol_eff && (vcnt_q != '1)) begin
            vcnt_d = vcnt_q + CNT_W'(1);
        end
        if (escape && (ecnt_q != '1)) begin
            ecnt_d = ecnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            vcnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            vcnt_q <= vcnt_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign VCNT = vcnt_q;
    assign ECNT = ecnt_q;
`else
    logic unused_stats;
    assign unused_stats = escape;
    assign VCNT         = '0;
    assign ECNT         = '0;
`endif

endmodule

// File: tb/tb_sync_chain_x.sv
// Directed, table-driven bench for sync_chain_x (WIDTH=4, STAGES=2); a second
// instance with CNT_W=4 covers counter saturation. Counter expectations follow SYNC_CHAIN_X_STATS_EN.
module tb_sync_chain_x;

`ifdef SYNC_CHAIN_X_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CK;
    logic        RS;
    logic [3:0]  D, rD;
    logic        V, rV;
    logic [3:0]  Q, T;
    logic        M;
    logic [15:0] VCNT, ECNT;
    logic [3:0]  q_s, t_s;
    logic        m_s;
    logic [3:0]  vcnt_s, ecnt_s;

    int passed;
    int total;

    sync_chain_x #(.WIDTH(4), .STAGES(2), .CNT_W(16)) dut (
        .CK(CK), .RS(RS), .D(D), .V(V), .rD(rD), .rV(rV),
        .Q(Q), .T(T), .M(M), .VCNT(VCNT), .ECNT(ECNT)
    );

    sync_chain_x #(.WIDTH(4), .STAGES(2), .CNT_W(4)) dut_sat (
        .CK(CK), .RS(RS), .D(D), .V(V), .rD(rD), .rV(rV),
        .Q(q_s), .T(t_s), .M(m_s), .VCNT(vcnt_s), .ECNT(ecnt_s)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct {
        logic [3:0] d;
        logic       v;
        logic [3:0] rd;
        logic       rv;
        logic [3:0] q;
        logic [3:0] t;
        logic       m;
        int         vcnt;
        int         ecnt;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    function automatic logic [31:0] cnt(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    initial begin
        passed = 0;
        total  = 0;
        RS = 1'b0; D = '0; V = 1'b0; rD = '0; rV = 1'b0;

        //            d     v  rd    rv   q     t     m  vcnt ecnt
        vecs[0]  = '{4'h0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0};
        vecs[1]  = '{4'hA, 0, 4'h0, 0, 4'h0, 4'h0, 0, 0, 0};
        vecs[2]  = '{4'hA, 0, 4'h0, 0, 4'hA, 4'hA, 0, 0, 0};
        vecs[3]  = '{4'hA, 0, 4'h0, 0, 4'hA, 4'h0, 0, 0, 0};
        vecs[4]  = '{4'h0, 0, 4'h0, 0, 4'hA, 4'h0, 0, 0, 0};
        vecs[5]  = '{4'hF, 1, 4'h5, 0, 4'h0, 4'hA, 0, 1, 0};
        vecs[6]  = '{4'h5, 0, 4'h0, 0, 4'h5, 4'h5, 0, 1, 0};
        vecs[7]  = '{4'h3, 0, 4'h0, 0, 4'h5, 4'h0, 0, 1, 0};
        vecs[8]  = '{4'h3, 1, 4'hC, 1, 4'h3, 4'h6, 0, 1, 0};
        vecs[9]  = '{4'h3, 0, 4'h0, 1, 4'h3, 4'h0, 0, 1, 0};
        vecs[10] = '{4'hC, 1, 4'h9, 1, 4'h3, 4'h0, 0, 2, 0};
        vecs[11] = '{4'h9, 0, 4'h0, 1, 4'h9, 4'hA, 1, 2, 1};
        vecs[12] = '{4'h9, 0, 4'h0, 0, 4'h9, 4'h0, 0, 2, 1};
        vecs[13] = '{4'h6, 1, 4'h2, 1, 4'h9, 4'h0, 0, 3, 1};
        vecs[14] = '{4'h2, 0, 4'h0, 0, 4'h2, 4'hB, 0, 3, 1};
        vecs[15] = '{4'hE, 1, 4'h5, 0, 4'h2, 4'h0, 0, 4, 1};
        vecs[16] = '{4'h6, 0, 4'h0, 0, 4'h6, 4'h4, 0, 4, 1};
        vecs[17] = '{4'h9, 1, 4'h0, 1, 4'h6, 4'h0, 0, 5, 1};
        vecs[18] = '{4'hF, 1, 4'hA, 1, 4'h0, 4'h6, 1, 6, 2};
        vecs[19] = '{4'hA, 0, 4'h0, 1, 4'hA, 4'hA, 1, 6, 3};
        vecs[20] = '{4'hA, 0, 4'h0, 1, 4'hA, 4'h0, 0, 6, 3};

        // Reset state before any clock edge.
        #3;
        check("rst_q", 32'(Q), 32'h0);
        check("rst_t", 32'(T), 32'h0);
        check("rst_m", 32'(M), 32'h0);
        check("rst_vcnt", 32'(VCNT), 32'h0);
        check("rst_ecnt", 32'(ECNT), 32'h0);
        step();
        #2;
        RS = 1'b1;

        for (int i = 0; i < 21; i++) begin
            D = vecs[i].d; V = vecs[i].v; rD = vecs[i].rd; rV = vecs[i].rv;
            step();
            check($sformatf("q[%0d]", i), 32'(Q), 32'(vecs[i].q));
            check($sformatf("t[%0d]", i), 32'(T), 32'(vecs[i].t));
            check($sformatf("m[%0d]", i), 32'(M), 32'(vecs[i].m));
            check($sformatf("vcnt[%0d]", i), 32'(VCNT), cnt(vecs[i].vcnt));
            check($sformatf("ecnt[%0d]", i), 32'(ECNT), cnt(vecs[i].ecnt));
        end

        // Twenty effective violations: the CNT_W=4 counter must stick at 0xF.
        check("sat_start", 32'(vcnt_s), cnt(6));
        V = 1'b1; rV = 1'b0;
        for (int i = 0; i < 20; i++) begin
            D  = (i % 2 == 0) ? 4'h5 : 4'hA;
            rD = D;
            step();
            if (i == 8) check("sat_at_15", 32'(vcnt_s), cnt(15));
        end
        check("sat_hold", 32'(vcnt_s), cnt(15));
        check("sat_main", 32'(VCNT), cnt(26));
        check("sat_q", 32'(Q), 32'h5);

        // Set up an escape with data in flight, then reset between edges.
        D = 4'h5; V = 1'b1; rD = 4'h5; rV = 1'b1;
        step();
        V = 1'b0;
        step();
        check("pre_rst_m", 32'(M), 32'h1);
        check("pre_rst_q", 32'(Q), 32'h5);
        check("pre_rst_ecnt", 32'(ECNT), cnt(4));
        #2;
        RS = 1'b0;
        #1;
        check("mid_rst_q", 32'(Q), 32'h0);
        check("mid_rst_t", 32'(T), 32'h0);
        check("mid_rst_m", 32'(M), 32'h0);
        check("mid_rst_vcnt", 32'(VCNT), 32'h0);
        check("mid_rst_ecnt", 32'(ECNT), 32'h0);
        check("mid_rst_vcnt_sat", 32'(vcnt_s), 32'h0);
        #1;
        RS = 1'b1;
        D = 4'h3; V = 1'b0; rV = 1'b0;
        step();
        check("post_rst_q1", 32'(Q), 32'h0);
        check("post_rst_t1", 32'(T), 32'h0);
        step();
        check("post_rst_q2", 32'(Q), 32'h3);
        check("post_rst_t2", 32'(T), 32'h3);
        check("post_rst_m", 32'(M), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sync_chain_x.md
SYNC_CHAIN_X -- requirements
Module: sync_chain_x

Interface
REQ-001 Parameter WIDTH, default 4: data bits per stage; legal range 1..32.
REQ-002 Parameter STAGES, default 2: synchroniser depth; legal range 2..8.
REQ-003 Parameter CNT_W, default 16: width of the statistics counters; legal range 4..32.
REQ-004 CK  input  1  sole clock; all state updates on its rising edge.
REQ-005 RS  input  1  reset; asynchronous and active-low.
REQ-006 D  input  WIDTH  asynchronous-domain data sampled by stage 0.
REQ-007 V  input  1  setup/hold violation indicator for the current stage-0 capture.
REQ-008 rD  input  WIDTH  free random data; replaces the changing bits on a violating capture.
REQ-009 rV  input  1  free random bit; decides whether metastability persists one more stage.
REQ-010 Q  output  WIDTH  last-stage data, STAGES cycles after D in the absence of violations.
REQ-011 T  output  WIDTH  per-bit toggle mark: Q bits that changed on the most recent edge.
REQ-012 M  output  1  metastability reached the last stage, registered.
REQ-013 VCNT  output  CNT_W  count of effective violations.
REQ-014 ECNT  output  CNT_W  count of escapes (M asserted).

Function
REQ-015 chg = D XOR s[0]; a violation is effective when V=1 and chg is non-zero.
REQ-016 Stage 0 captures D when V=0; when V=1 it captures (D AND NOT chg) OR (rD AND chg), randomising only the changing bits.
REQ-017 For k>=1, s[k] captures s[k-1] on every edge; Q = s[STAGES-1].
REQ-018 Metastability flag m[0] captures (V AND rV AND chg!=0); for k>=1, m[k] captures (m[k-1] AND rV).
REQ-019 M = m[STAGES-1], so an escape requires rV=1 on STAGES consecutive relevant edges.
REQ-020 T captures s[STAGES-2] XOR s[STAGES-1] on each edge, so T equals the bits of Q that changed on that edge.
REQ-021 A violation with chg=0 (V=1, D equal to s[0]) is ignored: data is unchanged, m[0]=0 and VCNT is not incremented.
REQ-022 VCNT increments by 1 on each effective violation and saturates at all-ones.
REQ-023 ECNT increments by 1 on each edge where m[STAGES-2] AND rV is 1 (the same edge M sets), and saturates at all-ones.
REQ-024 Outputs are purely registered; there is no combinational path from any input to any output.
REQ-025 Back-to-back violations are handled independently each cycle; flags in different stages coexist.

Reset
REQ-026 RS low clears all s[k], m[k] and T to 0, immediately and without a clock.
REQ-027 RS low clears Q, M, VCNT and ECNT to 0.
REQ-028 Reset asserted mid-propagation discards all in-flight data and flags.
REQ-029 The first capture occurs on the first CK rising edge after RS deasserts.

Configuration
REQ-030 Macro SYNC_CHAIN_X_STATS_EN defined: the VCNT and ECNT counters are implemented as specified in REQ-022 and REQ-023.
REQ-031 Macro SYNC_CHAIN_X_STATS_EN undefined: no counter flops are built and VCNT and ECNT are tied to constant 0; all other behaviour is identical.

Verification
REQ-032 Scenario: WIDTH=4, STAGES=2, V=0, D steps 0x0 to 0xA -> Q=0xA exactly 2 edges later; T=0xA on that edge, then 0x0.
REQ-033 Scenario: s[0]=0x0, D=0xF, V=1, rD=0x5, rV=0 -> s[0]=0x5; Q=0x5 2 edges later; M stays 0; VCNT=1.
REQ-034 Scenario: s[0]=0x3, D=0x3, V=1 -> no data change, m[0]=0, VCNT unchanged.
REQ-035 Scenario: effective violation with rV held at 1 for 2 edges -> M=1 on the 2nd edge; ECNT=1; with rV=0 on the 2nd edge -> M stays 0.
REQ-036 Scenario: CNT_W=4, 20 effective violations -> VCNT saturates at 0xF.
REQ-037 Scenario: RS pulsed low between clock edges with data in flight -> Q, T, M and counters read 0 immediately; both macro settings are built and run.
